sramlike_scratchpad: RTL and testbench

- Responder (slave) end of the team's SRAM-like data interface: req / addr_ok / data_ok, with wr, size, addr, wdata, wstrb and rdata.
- Backed by a local word-addressed RAM; stands in for the dcache behind the CPU-side store accelerator, both as a tightly-coupled scratchpad and as a bench target.
- Accepts one request per cycle, keeps up to QDEPTH outstanding, and returns data_ok strictly in acceptance order after a fixed latency.

---
 rtl/sramlike_scratchpad.sv | 130 +++++++++++++
 tb/tb_sramlike_scratchpad.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_scratchpad.sv
// SRAM-like responder backed by a local word RAM, in-order fixed-latency responses.
// Optional SP_STALL_EN adds LFSR-driven pseudo-random addr_ok stalls.
module sramlike_scratchpad #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0]    CNT_INIT = 3'(LATENCY - 1);
    localparam logic [CW-1:0] QFULL    = CW'(QDEPTH);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] word;
    logic hs, retire, stall;

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [2:0]        cnt_q [QDEPTH];
    logic [2:0]        cnt_d [QDEPTH];
    logic [31:0]       rd_q [QDEPTH];
    logic [31:0]       rd_d [QDEPTH];
    logic [31:0]       last_q, last_d;
    logic              unused;

    assign unused = ^{data_size, data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

    assign idx  = data_addr[ADDR_WIDTH+1:2];
    assign word = mem[idx];

`ifdef SP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Acceptance never looks at a same-cycle retirement.
    assign data_addr_ok = (count_q < QFULL) && !stall;
    assign hs           = data_req && data_addr_ok;
    assign data_data_ok = vld_q[head_q] && (cnt_q[head_q] == 3'd0);
    assign retire       = data_data_ok;
    assign data_rdata   = data_data_ok ? rd_q[head_q] : last_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        last_d = last_q;
        for (int i = 0; i < QDEPTH; i++) begin
            rd_d[i]  = rd_q[i];
            cnt_d[i] = (vld_q[i] && cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1
                                                      : cnt_q[i];
        end
        if (retire) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
            last_d        = rd_q[head_q];
        end
        if (hs) begin
            vld_d[tail_q] = 1'b1;
            cnt_d[tail_q] = CNT_INIT;
            rd_d[tail_q]  = word;
            tail_d        = tail_q + PW'(1);
        end
        count_d = count_q + CW'(hs) - CW'(retire);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                cnt_q[i] <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            for (int i = 0; i < QDEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
                rd_q[i]  <= rd_d[i];
            end
        end
    end

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (hs && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sramlike_scratchpad.sv
// Bench for sramlike_scratchpad: two instances (LATENCY 2 and 7)
// checked every cycle against a queue-based response model.
module tb_sramlike_scratchpad;
    localparam int QD = 4;

    typedef struct {
        bit          wr;
        bit          known;
        logic [31:0] rd;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  aok;
    logic [1:0]  dok;
    logic [31:0] rdat [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h expected=%h t=%0t",
                     nm, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : 7;

        exp_t        q[$];
        logic [31:0] mm [int];
        int          cyc = 0;
        int          dokcnt = 0;
        bit          last_known = 1'b1;
        logic [31:0] last_rd = '0;

        sramlike_scratchpad #(
            .ADDR_WIDTH(10),
            .LATENCY   (LAT),
            .QDEPTH    (QD)
        ) dut (
            .clk         (clk),
            .resetn      (resetn),
            .data_req    (req),
            .data_wr     (wr),
            .data_size   (size),
            .data_addr   (addr),
            .data_wdata  (wdata),
            .data_wstrb  (wstrb),
            .data_rdata  (rdat[g]),
            .data_addr_ok(aok[g]),
            .data_data_ok(dok[g])
        );

        always begin
            bit          exp_dok;
            int          i;
            exp_t        e;
            logic [31:0] w;
            @(negedge clk);
            if (dok[g]) dokcnt++;
            if (!resetn) begin
                q.delete();
                last_known = 1'b1;
                last_rd    = '0;
                check("rst_dok", g, 32'(dok[g]), 32'd0);
                check("rst_rdata", g, rdat[g], 32'd0);
                check("rst_aok", g, 32'(aok[g]), 32'd1);
            end else begin
                exp_dok = (q.size() > 0) && (q[0].due == cyc);
                check("data_ok", g, 32'(dok[g]), 32'(exp_dok));
                check("addr_ok", g, 32'(aok[g]), 32'(q.size() < QD));
                if (exp_dok && !q[0].wr && q[0].known)
                    check("rdata", g, rdat[g], q[0].rd);
                else if (!exp_dok && last_known)
                    check("rdata_hold", g, rdat[g], last_rd);
            end
            #3;
            if (resetn) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    last_known = !q[0].wr && q[0].known;
                    last_rd    = q[0].rd;
                    void'(q.pop_front());
                end
                if (req && aok[g]) begin
                    i       = int'((addr >> 2) & 32'h3FF);
                    e.wr    = wr;
                    e.known = mm.exists(i);
                    e.rd    = e.known ? mm[i] : 32'd0;
                    e.due   = cyc + LAT;
                    q.push_back(e);
                    if (wr) begin
                        if (wstrb == 4'hF) begin
                            mm[i] = wdata;
                        end else if (mm.exists(i)) begin
                            w = mm[i];
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
                            mm[i] = w;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // Single request on instance 0, returning its read data and latency.
    task automatic op(input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd,
                      output int lat);
        int n;
        @(negedge clk);
        #1;
        req = 1'b1; wr = w; addr = a; wdata = wd; wstrb = st;
        size = 2'($urandom_range(0, 2));
        n = 0;
        while (!aok[0] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("accept_timeout", 0, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
        rd  = '0;
        for (lat = 1; lat <= 12; lat++) begin
            @(negedge clk);
            if (dok[0]) break;
        end
        if (lat > 12) check("dok_timeout", 0, 32'd1, 32'd0);
        rd = rdat[0];
    endtask

    initial begin
        logic [31:0] rd;
        int lat, acc0, acc1, base0, base1;

        @(negedge clk);
        #1;
        check("lit_rst_aok", 0, 32'(aok[0]), 32'd1);
        check("lit_rst_dok", 0, 32'(dok[0]), 32'd0);
        check("lit_rst_rdata", 0, rdat[0], 32'd0);
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;

        op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        check("lit_wr_lat", 0, 32'(lat), 32'd2);
        op(1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("lit_rd_lat", 0, 32'(lat), 32'd2);
        check("lit_rd_data", 0, rd, 32'hDEADBEEF);

        op(1'b1, 32'h20, 32'h11223344, 4'hF, rd, lat);
        op(1'b1, 32'h21, 32'h0000AA00, 4'b0010, rd, lat);
        op(1'b0, 32'h22, 32'h0, 4'h0, rd, lat);
        check("lit_strobe", 0, rd, 32'h1122AA44);

        op(1'b1, 32'h00001004, 32'hCAFEF00D, 4'hF, rd, lat);
        op(1'b0, 32'h00000004, 32'h0, 4'h0, rd, lat);
        check("lit_alias", 0, rd, 32'hCAFEF00D);

        repeat (12) @(negedge clk);
        base0 = g_inst[0].dokcnt;
        base1 = g_inst[1].dokcnt;
        acc0 = 0;
        acc1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            req = 1'b1; wr = 1'b0; wstrb = 4'h0;
            addr = 32'($urandom_range(0, 15)) << 2;
            #2;
            if (aok[0]) acc0++;
            if (aok[1]) acc1++;
        end
        @(negedge clk);
        #1;
        req = 1'b0;
        repeat (20) @(negedge clk);
        check("lit_stream_acc_l2", 0, 32'(acc0), 32'd16);
        check("lit_stream_dok_l2", 0, 32'(g_inst[0].dokcnt - base0), 32'd16);
        check("lit_stream_acc_l7", 1, 32'(acc1), 32'd8);
        check("lit_stream_dok_l7", 1, 32'(g_inst[1].dokcnt - base1), 32'd8);

        @(negedge clk);
        #1;
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        req    = 1'b0;
        #1;
        check("lit_rst_imm_l2", 0, 32'(dok[0]), 32'd0);
        check("lit_rst_imm_l7", 1, 32'(dok[1]), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        op(1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("lit_post_rst_lat", 0, 32'(lat), 32'd2);
        check("lit_post_rst_data", 0, rd, 32'hDEADBEEF);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            req   = ($urandom_range(0, 9) < 7);
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            wstrb = 4'($urandom_range(0, 15));
            wdata = $urandom;
            addr  = ($urandom & 32'hFFFF_F000)
                  | (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
        end
        @(negedge clk);
        #1;
        req = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
